// File: rtl/loader_pkg.sv
// loader_pkg: shared state types, 8N1 frame constants and baud helper for the imem loader.
package loader_pkg;
    typedef enum logic [2:0] {HDR0, HDR1, DATA, DONE, ERR} loader_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    localparam int DATA_BITS = 8;
    localparam logic STOP_LEVEL = 1'b1;
    function automatic int bit_cyc(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first receiver, mid-bit sampling with a false-start re-check.
module uart_rx import loader_pkg::*; #(
    parameter int BIT_CYC = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_sync,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYC / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYC - 1);
    if (BIT_CYC < 4) begin : g_bit_cyc_check
        $error("uart_rx: BIT_CYC must be at least 4");
    end
    rx_state_t state, next_state;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic prev;
    logic fall, tick;
    assign fall = prev & ~rx_sync;
    assign tick = cnt == (state == RX_START ? HALF_M1 : FULL_M1);
    always_comb begin
        next_state = state;
        case (state)
            RX_IDLE:  next_state = fall ? RX_START : RX_IDLE;
            RX_START: next_state = !tick ? RX_START : rx_sync ? RX_IDLE : RX_BITS;
            RX_BITS:  next_state = tick && idx == 3'(DATA_BITS - 1) ? RX_STOP : RX_BITS;
            default:  next_state = tick ? RX_IDLE : RX_STOP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset)
            state <= RX_IDLE;
        else
            state <= next_state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            prev       <= 1'b1;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            prev       <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            cnt        <= (state == RX_IDLE || tick) ? '0 : cnt + 1'b1;
            if (state == RX_BITS && tick) begin
                byte_data <= {rx_sync, byte_data[7:1]};
                idx       <= idx + 3'd1;
            end
            if (state == RX_STOP && tick) begin
                byte_valid <= rx_sync == STOP_LEVEL;
                frame_err  <= rx_sync != STOP_LEVEL;
            end
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed program image over UART, writes it into imem
// and holds the core in reset until the image is complete.
module imem_loader import loader_pkg::*; #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);
    localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
    localparam logic [16:0] CAP = 17'(2 ** ADDR_W);
    logic [1:0] rx_sr;
    logic [2:0] lr_sr;
    logic byte_valid, frame_err;
    logic [7:0] byte_data;
    loader_state_t state, next_state;
    logic [15:0] n, n_hi;
    logic [1:0] idx;
    logic [23:0] part;
    logic load_rise, word_end, last_word, rearm;
    uart_rx #(.BIT_CYC(BIT_CYC)) u_rx (
        .clk(clk),
        .reset(reset),
        .rx_sync(rx_sr[1]),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .frame_err(frame_err)
    );
    assign load_rise = lr_sr[1] & ~lr_sr[2];
    assign n_hi      = {byte_data, n[7:0]};
    assign word_end  = state == DATA && byte_valid && idx == 2'd3;
    assign last_word = 16'(word_cnt) + 16'd1 == n;
    assign rearm     = next_state == HDR0 && state != HDR0;
    assign busy      = state == HDR0 || state == HDR1 || state == DATA;
    assign err       = state == ERR;
    always_comb begin
        next_state = state;
        case (state)
            HDR0:    next_state = frame_err ? ERR : byte_valid ? HDR1 : HDR0;
            HDR1:    next_state = frame_err ? ERR : !byte_valid ? HDR1 : n_hi == 16'd0 ? DONE : 17'(n_hi) > CAP ? ERR : DATA;
            DATA:    next_state = frame_err ? ERR : word_end && last_word ? DONE : DATA;
            default: next_state = load_rise ? HDR0 : state;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR0;
            rx_sr <= '1;
            lr_sr <= '0;
        end else begin
            state <= next_state;
            rx_sr <= {rx_sr[0], rx};
            lr_sr <= {lr_sr[1:0], load_req};
        end
    end
    // The last-word path releases the core one cycle after its write, the N==0 path immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            word_cnt   <= '0;
            cpu_reset  <= 1'b1;
            n          <= '0;
            idx        <= '0;
            part       <= '0;
        end else begin
            imem_we   <= word_end;
            cpu_reset <= next_state != DONE || state == DATA;
            if (state == HDR0 && byte_valid)
                n[7:0] <= byte_data;
            if (state == HDR1 && byte_valid)
                n[15:8] <= byte_data;
            if (state == DATA && byte_valid) begin
                part <= {byte_data, part[23:8]};
                idx  <= idx + 2'd1;
            end
            if (word_end) begin
                imem_waddr <= word_cnt[ADDR_W-1:0];
                imem_wdata <= {byte_data, part};
                word_cnt   <= word_cnt + 1'b1;
            end
            if (next_state == ERR || rearm)
                idx <= '0;
            if (rearm)
                word_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed UART image loads checked against a byte-count model of the loader.
module tb_imem_loader;
    logic clk = 0, reset = 1, rx = 1, load_req = 0;
    logic imem_we, cpu_reset, busy, err;
    logic [3:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [4:0] word_cnt;
    imem_loader #(.CLK_FREQ(16), .BAUD(1), .ADDR_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .load_req(load_req),
        .imem_we(imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset),
        .busy(busy),
        .err(err),
        .word_cnt(word_cnt)
    );
    always #5 clk = ~clk;
    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    // Model: bytes accepted since arm, header length, words completed, error flag.
    int m_cnt = 0, m_n = 0, m_words = 0;
    bit m_err = 0;
    logic [31:0] m_word = 0;
    logic [35:0] exp_q[$];
    logic [31:0] mem [16];
    int start_cyc = 0, fall_cyc = -100, last_we_cyc = -100, wr_count = 0;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask
    function automatic bit m_done();
        return m_cnt >= 2 && !m_err && m_words == m_n;
    endfunction
    function automatic void model_reset();
        m_cnt = 0; m_n = 0; m_words = 0; m_err = 0; m_word = 0;
    endfunction
    function automatic void model_byte(input logic [7:0] b, input bit ok);
        if (m_err || m_done()) return;
        if (!ok) begin
            m_err = 1;
            return;
        end
        if (m_cnt < 2)
            m_n += int'(b) << (8 * m_cnt);
        else begin
            m_word[8 * ((m_cnt - 2) % 4) +: 8] = b;
            if ((m_cnt - 2) % 4 == 3) begin
                exp_q.push_back({4'(m_words), m_word});
                m_words++;
            end
        end
        m_cnt++;
        if (m_cnt == 2 && m_n > 16) m_err = 1;
    endfunction
    logic prev_we = 0, prev_cr = 1;
    logic [35:0] mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %0h data %08h, none expected", imem_waddr, imem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write_addr", 32'(imem_waddr), 32'(mon_e[35:32]));
                    chk("write_data", imem_wdata, mon_e[31:0]);
                end
                chk("we_single_cycle", 32'(prev_we), 0);
                mem[imem_waddr] = imem_wdata;
                last_we_cyc = cyc;
                wr_count++;
            end
            chk("busy_implies_cpu_reset", 32'(busy && !cpu_reset), 0);
            chk("err_implies_held", 32'(err && (!cpu_reset || busy)), 0);
            if (prev_cr && !cpu_reset) fall_cyc = cyc;
        end
        prev_we = imem_we;
        prev_cr = cpu_reset;
    end
    task automatic send(input logic [7:0] b, input bit stop = 1);
        model_byte(b, stop);
        @(negedge clk);
        rx = 0;
        start_cyc = cyc;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop;
        repeat (16) @(negedge clk);
        rx = 1;
        repeat (stop ? 4 : 20) @(negedge clk);
    endtask
    task automatic pulse_load(input bit rearms);
        @(negedge clk);
        load_req = 1;
        repeat (6) @(negedge clk);
        load_req = 0;
        repeat (6) @(negedge clk);
        if (rearms) model_reset();
    endtask
    task automatic check_levels(input string tag);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!m_done()));
        chk({tag, "_busy"}, 32'(busy), 32'(!m_done() && !m_err));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
        chk({tag, "_word_cnt"}, 32'(word_cnt), 32'(m_words));
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 0);
    endtask
    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"}, 32'(imem_we), 0);
        chk({tag, "_waddr"}, 32'(imem_waddr), 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 1);
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_word_cnt"}, 32'(word_cnt), 0);
    endtask
    int w0;
    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 0;
        repeat (4) @(negedge clk);
        // Basic load: two words.
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h05); send(8'hA0); send(8'h00);
        send(8'h93); send(8'h05); send(8'hF0); send(8'hFF);
        check_levels("basic");
        chk("basic_word_cnt", 32'(word_cnt), 2);
        chk("basic_mem0", mem[0], 32'h00A00513);
        chk("basic_mem1", mem[1], 32'hFFF00593);
        chk("basic_fall_after_last_we", 32'(fall_cyc - last_we_cyc), 1);
        send(8'h55);
        check_levels("done_ignores");
        // Empty image.
        pulse_load(1);
        check_levels("rearm1");
        w0 = wr_count;
        send(8'h00); send(8'h00);
        check_levels("empty");
        chk("empty_no_writes", 32'(wr_count - w0), 0);
        chk("empty_fall_mid_stop", 32'(fall_cyc - start_cyc >= 150 && fall_cyc - start_cyc <= 160), 1);
        // Oversize header.
        pulse_load(1);
        send(8'h11); send(8'h00);
        check_levels("oversize");
        chk("oversize_err", 32'(err), 1);
        pulse_load(1);
        check_levels("rearm_from_err");
        chk("rearm_err_clear", 32'(err), 0);
        // Framing error mid word 1; a load_req edge while loading is ignored.
        send(8'h02); send(8'h00);
        pulse_load(0);
        check_levels("ignored_load_req");
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66);
        send(8'h77, 0);
        check_levels("frame_err");
        chk("frame_err_word_cnt", 32'(word_cnt), 1);
        chk("frame_err_mem0", mem[0], 32'h44332211);
        send(8'h88);
        check_levels("err_ignores");
        // Reset mid-load.
        pulse_load(1);
        send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check_reset_vals("mid_reset");
        reset = 0;
        model_reset();
        repeat (4) @(negedge clk);
        // Short rx glitch must not produce a byte.
        rx = 0;
        repeat (4) @(negedge clk);
        rx = 1;
        repeat (200) @(negedge clk);
        check_levels("glitch");
        send(8'h01); send(8'h00); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        check_levels("reload");
        chk("reload_mem0", mem[0], 32'hDEADBEEF);
        chk("reload_word_cnt", 32'(word_cnt), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
